// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store sequencer between the CPU datapath and a 16-bit-granular,
// big-endian 32-bit data RAM. A byte/half/word request on a byte address is
// turned into registered RAM commands. Load data is extracted from the RAM word
// and sign/zero-extended. Byte stores do a read-modify-write of the containing
// halfword. Completion is a one-cycle resp_valid pulse.
//
// Optional feature macro: MAU_MISALIGN_TRAP_EN
//   defined   : misaligned or reserved-size requests complete at once with
//               resp_err=1 and resp_rdata=0, without touching the RAM.
//   undefined : low address bits are forced to the natural alignment, size 2'b11
//               is handled as a word access, and resp_err is always 0.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved
//   req_signed      loads: 1 sign-extend, 0 zero-extend
//   req_addr        byte address (byte 0 = bits [31:24])
//   req_wdata       store data, right-justified for byte/half
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores), held between responses
//   resp_err        misaligned/reserved request, qualifies resp_valid
//   mem_we          RAM write enable
//   mem_addr        RAM word address (req_addr[ADDR_W-1:2])
//   mem_byte_sel    RAM half select: 0 = [31:16], 1 = [15:0]
//   mem_half_w      RAM halfword mode (half and byte ops)
//   mem_wdata       RAM write data; halfword writes use [15:0]
//   mem_rdata       RAM read data, valid the cycle after the read address
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_byte_sel,
  output logic              mem_half_w,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AW_WORD = ADDR_W - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPT    = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_CAP = 3'd4,
    ST_WRITE   = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  // Select the addressed byte/half/word of a big-endian RAM word and extend it.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [DATA_W-1:0] rd,
    input logic [1:0]        size,
    input logic [1:0]        lo,
    input logic              sgn
  );
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = lo[1] ? rd[15:0] : rd[31:16];
    byte_v = lo[0] ? half_v[7:0] : half_v[15:8];
    case (size)
      SZ_BYTE: extract_load = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_HALF: extract_load = {{16{sgn & half_v[15]}}, half_v};
      default: extract_load = rd;
    endcase
  endfunction

  // Replace one byte of the addressed halfword, keeping its other byte.
  function automatic logic [15:0] merge_byte(
    input logic [DATA_W-1:0] rd,
    input logic [1:0]        lo,
    input logic [7:0]        wb
  );
    logic [15:0] half_v;
    half_v = lo[1] ? rd[15:0] : rd[31:16];
    if (lo[0]) begin
      merge_byte = {half_v[15:8], wb};
    end else begin
      merge_byte = {wb, half_v[7:0]};
    end
  endfunction

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [AW_WORD-1:0]  mem_addr_q, mem_addr_d;
  logic                mem_byte_sel_q, mem_byte_sel_d;
  logic                mem_half_w_q, mem_half_w_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          lo_q, lo_d;
  logic                signed_q, signed_d;
  logic                store_q, store_d;
  logic                err_q, err_d;

  // Request decode as seen at the accept edge.
  logic [1:0]          acc_size_s;
  logic [1:0]          acc_lo_s;
  logic                trap_s;

`ifdef MAU_MISALIGN_TRAP_EN
  logic                misalign_s;

  // Flag requests that are not naturally aligned for their size.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size)
      SZ_BYTE: misalign_s = 1'b0;
      SZ_HALF: misalign_s = req_addr[0];
      SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b1;
    endcase
  end

  assign trap_s     = misalign_s;
  assign acc_size_s = req_size;
  assign acc_lo_s   = req_addr[1:0];
`else
  assign trap_s     = 1'b0;
  assign acc_size_s = (req_size == SZ_RSVD) ? SZ_WORD : req_size;

  // Force the low address bits down to the natural alignment of the access.
  always_comb begin
    acc_lo_s = 2'b00;
    case (acc_size_s)
      SZ_BYTE: acc_lo_s = req_addr[1:0];
      SZ_HALF: acc_lo_s = {req_addr[1], 1'b0};
      default: acc_lo_s = 2'b00;
    endcase
  end
`endif

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_byte_sel_d = mem_byte_sel_q;
    mem_half_w_d   = mem_half_w_q;
    mem_wdata_d    = mem_wdata_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = resp_err_q;
    resp_rdata_d   = resp_rdata_q;
    load_data_d    = load_data_q;
    size_d         = size_q;
    lo_d           = lo_q;
    signed_d       = signed_q;
    store_d        = store_q;
    err_d          = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d   = acc_size_s;
          lo_d     = acc_lo_s;
          signed_d = req_signed;
          store_d  = req_we;
          err_d    = trap_s;
          if (trap_s) begin
            // Trapped request: answer straight away, RAM commands untouched.
            mem_we_d = 1'b0;
            state_d  = ST_RESP;
          end else begin
            mem_addr_d     = req_addr[ADDR_W-1:2];
            mem_byte_sel_d = acc_lo_s[1];
            mem_half_w_d   = (acc_size_s != SZ_WORD);
            if (acc_size_s == SZ_HALF) begin
              mem_wdata_d = {16'h0000, req_wdata[15:0]};
            end else begin
              // Byte stores keep the raw data; its low byte is merged later.
              mem_wdata_d = req_wdata;
            end
            if (!req_we) begin
              mem_we_d = 1'b0;
              state_d  = ST_READ;
            end else if (acc_size_s == SZ_BYTE) begin
              mem_we_d = 1'b0;
              state_d  = ST_RMW_RD;
            end else begin
              mem_we_d = 1'b1;
              state_d  = ST_WRITE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        state_d = ST_CAPT;
      end

      ST_CAPT: begin
        load_data_d = extract_load(mem_rdata, size_q, lo_q, signed_q);
        state_d     = ST_RESP;
      end

      ST_RMW_RD: begin
        state_d = ST_RMW_CAP;
      end

      ST_RMW_CAP: begin
        mem_wdata_d = {16'h0000, merge_byte(mem_rdata, lo_q, mem_wdata_q[7:0])};
        mem_we_d    = 1'b1;
        state_d     = ST_WRITE;
      end

      ST_WRITE: begin
        // The write enable lives exactly one cycle.
        mem_we_d = 1'b0;
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        if (store_q || err_q) begin
          resp_rdata_d = {DATA_W{1'b0}};
        end else begin
          resp_rdata_d = load_data_q;
        end
        state_d = ST_IDLE;
      end

      default: begin
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= {AW_WORD{1'b0}};
      mem_byte_sel_q <= 1'b0;
      mem_half_w_q   <= 1'b0;
      mem_wdata_q    <= {DATA_W{1'b0}};
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= {DATA_W{1'b0}};
      load_data_q    <= {DATA_W{1'b0}};
      size_q         <= 2'b00;
      lo_q           <= 2'b00;
      signed_q       <= 1'b0;
      store_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_byte_sel_q <= mem_byte_sel_d;
      mem_half_w_q   <= mem_half_w_d;
      mem_wdata_q    <= mem_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      load_data_q    <= load_data_d;
      size_q         <= size_d;
      lo_q           <= lo_d;
      signed_q       <= signed_d;
      store_q        <= store_d;
      err_q          <= err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_byte_sel = mem_byte_sel_q;
  assign mem_half_w   = mem_half_w_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_access_unit: the driver pushes the expected response
// (data, error flag, due cycle) on every accept; a monitor pops and compares on
// every resp_valid. A behavioural halfword-capable RAM sits on the mem_* port.
module tb_mem_access_unit;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic        mem_byte_sel;
  logic        mem_half_w;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_byte_sel (mem_byte_sel),
    .mem_half_w   (mem_half_w),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic        last_we_half_w = 1'b0;
  logic [12:0] last_we_addr = 13'd0;
  int          last_acc = 0;
  int          last_wait = 0;
  logic [31:0] ram [0:8191];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, full-word or halfword write.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      if (!mem_half_w) ram[mem_addr] <= mem_wdata;
      else if (!mem_byte_sel) ram[mem_addr][31:16] <= mem_wdata[15:0];
      else ram[mem_addr][15:0] <= mem_wdata[15:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-enable monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        last_we_half_w = mem_half_w;
        last_we_addr   = mem_addr;
      end
    end
  end

  // Response monitor: pops one expectation per resp_valid cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cyc);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Issue one request; push its expectation when the accept edge is next.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [14:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input logic hold);
    int   waits;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", waits);
      req_valid = 1'b0;
    end else begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = cyc + 1 + lat;
      sb_q.push_back(e);
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic sgn,
                    input logic [14:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    do_req(we, size, sgn, addr, wdata, exp_rdata, exp_err, lat, 1'b0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    int prev_acc;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 15'h0000;
    req_wdata  = 32'h0;
    prev_acc   = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_ctrl", 32'({mem_byte_sel, mem_half_w}), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // T1: word store then word load
    we0 = we_cnt;
    op(1'b1, SZ_WORD, 1'b0, 15'h0010, 32'h12345678, 32'h0, 1'b0, 2);
    check("t1_store_we_count", 32'(we_cnt - we0), 32'd1);
    check("t1_store_half_w", 32'(last_we_half_w), 32'd0);
    check("t1_store_addr", 32'(last_we_addr), 32'd4);
    we0 = we_cnt;
    op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 32'h12345678, 1'b0, 3);
    check("t1_load_we_count", 32'(we_cnt - we0), 32'd0);

    // T2: sub-word loads and a byte store into the low half
    op(1'b0, SZ_HALF, 1'b1, 15'h0012, 32'h0, 32'h00005678, 1'b0, 3);
    op(1'b0, SZ_BYTE, 1'b1, 15'h0011, 32'h0, 32'h00000034, 1'b0, 3);
    we0 = we_cnt;
    op(1'b1, SZ_BYTE, 1'b0, 15'h0013, 32'h00000080, 32'h0, 1'b0, 4);
    check("t2_bstore_we_count", 32'(we_cnt - we0), 32'd1);
    check("t2_bstore_half_w", 32'(last_we_half_w), 32'd1);
    op(1'b0, SZ_BYTE, 1'b1, 15'h0013, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    op(1'b0, SZ_BYTE, 1'b0, 15'h0013, 32'h0, 32'h00000080, 1'b0, 3);
    op(1'b1, SZ_HALF, 1'b0, 15'h0010, 32'h1234BEEF, 32'h0, 1'b0, 2);
    op(1'b0, SZ_HALF, 1'b1, 15'h0010, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
    op(1'b0, SZ_HALF, 1'b0, 15'h0010, 32'h0, 32'h0000BEEF, 1'b0, 3);
    op(1'b0, SZ_BYTE, 1'b1, 15'h0010, 32'h0, 32'hFFFFFFBE, 1'b0, 3);
    op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 32'hBEEF5680, 1'b0, 3);

    // T3: byte store into the upper byte preserves the rest
    op(1'b1, SZ_WORD, 1'b0, 15'h0010, 32'h12345678, 32'h0, 1'b0, 2);
    we0 = we_cnt;
    op(1'b1, SZ_BYTE, 1'b0, 15'h0010, 32'h000000AB, 32'h0, 1'b0, 4);
    check("t3_bstore_we_count", 32'(we_cnt - we0), 32'd1);
    op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 32'hAB345678, 1'b0, 3);

    // T4: reset while in RMW_CAP of a byte store
    we0 = we_cnt;
    @(negedge clk);
    check("t4_ready_before", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = 15'h0011;
    req_wdata  = 32'h000000CD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_ready_after_rst", 32'(req_ready), 32'd1);
    check("t4_mem_we_after_rst", 32'(mem_we), 32'd0);
    check("t4_resp_valid_after_rst", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_we_count", 32'(we_cnt - we0), 32'd0);
    check("t4_ram_word", ram[13'd4], 32'hAB345678);

    // T5: misaligned and reserved-size requests
`ifdef MAU_MISALIGN_TRAP_EN
    op(1'b0, SZ_WORD, 1'b0, 15'h0012, 32'h0, 32'h0, 1'b1, 1);
    op(1'b0, SZ_HALF, 1'b0, 15'h0013, 32'h0, 32'h0, 1'b1, 1);
    op(1'b0, SZ_RSVD, 1'b0, 15'h0010, 32'h0, 32'h0, 1'b1, 1);
    we0 = we_cnt;
    op(1'b1, SZ_WORD, 1'b0, 15'h0011, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    check("t5_trap_we_count", 32'(we_cnt - we0), 32'd0);
    op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 32'hAB345678, 1'b0, 3);
`else
    op(1'b0, SZ_WORD, 1'b0, 15'h0012, 32'h0, 32'hAB345678, 1'b0, 3);
    op(1'b0, SZ_HALF, 1'b0, 15'h0013, 32'h0, 32'h00005678, 1'b0, 3);
    op(1'b0, SZ_RSVD, 1'b0, 15'h0010, 32'h0, 32'hAB345678, 1'b0, 3);
    we0 = we_cnt;
    op(1'b1, SZ_WORD, 1'b0, 15'h0011, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("t5_align_we_count", 32'(we_cnt - we0), 32'd1);
    op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 3);
`endif

    // T6: back-to-back word stores with req_valid held high
    we0 = we_cnt;
    for (int i = 0; i < 10; i++) begin
      do_req(1'b1, SZ_WORD, 1'b0, 15'h0100 + 15'(i * 4), 32'hA5000000 + 32'(i),
             32'h0, 1'b0, 2, (i < 9));
      if (i > 0) begin
        check("t6_accept_spacing", 32'(last_acc - prev_acc), 32'd3);
        check("t6_ready_low_cycles", 32'(last_wait), 32'd2);
      end
      prev_acc = last_acc;
    end
    wait_drain();
    check("t6_we_count", 32'(we_cnt - we0), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("t6_ram_word", ram[13'h040 + 13'(i)], 32'hA5000000 + 32'(i));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
